// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC generation, single-outstanding memory handshake,
// small prefetch FIFO feeding decode, and branch redirect with refill tracking.
module fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [15:0] brTarget,
    input  logic        stall,
    output logic        iReq,
    output logic [15:0] iAddr,
    input  logic        iGnt,
    input  logic        iRdy,
    input  logic [15:0] dIn,
    output logic [15:0] fInst,
    output logic        fValid,
    output logic        refill
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

    logic [15:0]     fifoMem [DEPTH];
    logic [15:0]     pcQ, pcD;
    logic [PtrW-1:0] rdPtrQ, rdPtrD;
    logic [PtrW-1:0] wrPtrQ, wrPtrD;
    logic [CntW-1:0] countQ, countD;
    logic            outstandingQ, outstandingD;
    logic            dropQ, dropD;
    logic            refillQ, refillD;
    logic            issue, response, push, pop;

    assign refill = refillQ;

    // Request generation, head-of-queue presentation and handshake decode
    always_comb begin
        fValid = (countQ != '0);
        fInst  = fValid ? fifoMem[rdPtrQ] : NOP_INST;
        iAddr  = flush ? brTarget : pcQ;
        if (reset) begin
            iReq = 1'b0;
        end else if (flush) begin
            // Redirect may only go out once the old slot is free this cycle
            iReq = ~outstandingQ | iRdy;
        end else begin
            iReq = ~outstandingQ & (countQ < CountFull);
        end
        issue    = iReq & iGnt;
        response = iRdy & outstandingQ;
        push     = response & ~dropQ & ~flush;
        pop      = fValid & ~stall & ~flush;
    end

    // Next-state computation for PC, handshake tracking and FIFO bookkeeping
    always_comb begin
        pcD          = pcQ;
        outstandingD = outstandingQ;
        dropD        = dropQ;
        refillD      = refillQ;
        rdPtrD       = rdPtrQ;
        wrPtrD       = wrPtrQ;
        countD       = countQ;

        if (issue) begin
            pcD = iAddr + 16'd1;
        end else if (flush) begin
            pcD = brTarget;
        end

        if (issue) begin
            outstandingD = 1'b1;
        end else if (response) begin
            outstandingD = 1'b0;
        end

        if (flush) begin
            // A word still in flight belongs to the wrong path; discard it on arrival
            dropD   = outstandingQ & ~iRdy;
            refillD = 1'b1;
            rdPtrD  = '0;
            wrPtrD  = '0;
            countD  = '0;
        end else begin
            if (response) begin
                dropD = 1'b0;
            end
            if (fValid & ~stall) begin
                refillD = 1'b0;
            end
            if (push) begin
                wrPtrD = wrPtrQ + PtrW'(1);
            end
            if (pop) begin
                rdPtrD = rdPtrQ + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   countD = countQ + CntW'(1);
                2'b01:   countD = countQ - CntW'(1);
                default: countD = countQ;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pcQ          <= RESET_PC;
            outstandingQ <= 1'b0;
            dropQ        <= 1'b0;
            refillQ      <= 1'b1;
            rdPtrQ       <= '0;
            wrPtrQ       <= '0;
            countQ       <= '0;
        end else begin
            pcQ          <= pcD;
            outstandingQ <= outstandingD;
            dropQ        <= dropD;
            refillQ      <= refillD;
            rdPtrQ       <= rdPtrD;
            wrPtrQ       <= wrPtrD;
            countQ       <= countD;
        end
    end

    // FIFO storage; contents are qualified by countQ so no reset is needed
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifoMem[wrPtrQ] <= dIn;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by randomized traffic, all
// checked every cycle against a queue-based behavioural model of the fetch stage.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_INST = 16'h0000;

    logic        clk = 1'b0;
    logic        reset, flush, stall, iGnt, iRdy;
    logic [15:0] brTarget, dIn;
    logic        iReq, fValid, refill;
    logic [15:0] iAddr, fInst;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .brTarget (brTarget),
        .stall    (stall),
        .iReq     (iReq),
        .iAddr    (iAddr),
        .iGnt     (iGnt),
        .iRdy     (iRdy),
        .dIn      (dIn),
        .fInst    (fInst),
        .fValid   (fValid),
        .refill   (refill)
    );

    int nTests  = 0;
    int nFail   = 0;
    int cycleNo = 0;

    // Memory environment: in-order responder with per-request due cycle
    logic [15:0] memAddrQ[$];
    int          memDueQ[$];
    int          memLat   = 1;
    bit          randGnt  = 1'b0;
    bit          randLat  = 1'b0;
    bit          spurious = 1'b0;

    // Reference model: instruction queue, fetch pointer, in-flight/discard flags
    logic [15:0] mQ[$];
    logic [15:0] mPc;
    bit          mBusy, mDrop, mRefill;
    bit          justIssued;
    logic [15:0] lastIssued;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nTests++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycleNo);
        end
    endtask

    task automatic cycle();
        bit          expReq, expValid, memResp, resp, issue, pop;
        logic [15:0] expAddr, expInst;
        memResp = 1'b0;
        if (memAddrQ.size() > 0 && memDueQ[0] <= cycleNo) begin
            iRdy    = 1'b1;
            dIn     = 16'hA000 + memAddrQ[0];
            memResp = 1'b1;
        end else if (spurious && memAddrQ.size() == 0 && $urandom_range(0, 9) == 0) begin
            iRdy = 1'b1;
            dIn  = 16'($urandom);
        end else begin
            iRdy = 1'b0;
            dIn  = 16'hDEAD;
        end
        if (randGnt) iGnt = ($urandom_range(0, 9) < 7);
        #2;

        expAddr = flush ? brTarget : mPc;
        if (reset)      expReq = 1'b0;
        else if (flush) expReq = !mBusy || iRdy;
        else            expReq = !mBusy && (mQ.size() < DEPTH);
        expValid = (mQ.size() > 0);
        expInst  = expValid ? mQ[0] : NOP_INST;

        check("iReq",   {15'd0, iReq},   {15'd0, expReq});
        check("iAddr",  iAddr,           expAddr);
        check("fValid", {15'd0, fValid}, {15'd0, expValid});
        check("fInst",  fInst,           expInst);
        check("refill", {15'd0, refill}, {15'd0, mRefill});

        // Memory sees whatever the DUT actually requested
        if (memResp) begin
            void'(memAddrQ.pop_front());
            void'(memDueQ.pop_front());
        end
        if (iReq === 1'b1 && iGnt) begin
            memAddrQ.push_back(iAddr);
            memDueQ.push_back(cycleNo + (randLat ? int'($urandom_range(1, 3)) : memLat));
        end

        issue      = expReq && iGnt;
        resp       = iRdy && mBusy;
        justIssued = issue;
        if (issue) lastIssued = expAddr;
        if (reset) begin
            mPc = RESET_PC;
            mQ.delete();
            mBusy   = 1'b0;
            mDrop   = 1'b0;
            mRefill = 1'b1;
        end else begin
            if (flush) begin
                mQ.delete();
                mRefill = 1'b1;
                mDrop   = mBusy && !iRdy;
            end else begin
                pop = (mQ.size() > 0) && !stall;
                if (pop) begin
                    void'(mQ.pop_front());
                    mRefill = 1'b0;
                end
                if (resp) begin
                    if (mDrop) mDrop = 1'b0;
                    else       mQ.push_back(dIn);
                end
            end
            if (issue)     mPc = expAddr + 16'd1;
            else if (flush) mPc = brTarget;
            if (issue)     mBusy = 1'b1;
            else if (resp) mBusy = 1'b0;
        end

        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic waitIdle();
        int g = 0;
        while (mBusy && g < 20) begin
            cycle();
            g++;
        end
        check("idle_timeout", {15'd0, mBusy}, 16'd0);
    endtask

    initial begin
        int g;
        reset = 1'b1; flush = 1'b0; brTarget = 16'h0; stall = 1'b0;
        iGnt = 1'b0; iRdy = 1'b0; dIn = 16'h0;
        mPc = RESET_PC; mBusy = 1'b0; mDrop = 1'b0; mRefill = 1'b1;
        justIssued = 1'b0; lastIssued = 16'h0;
        @(posedge clk);
        #1;

        // Reset state, then streaming fetch with one-cycle memory
        cycle();
        reset = 1'b0; iGnt = 1'b1; memLat = 1;
        repeat (10) cycle();

        // Decode stall: FIFO fills, requests stop, then drains in order
        stall = 1'b1;
        repeat (6) cycle();
        stall = 1'b0;
        repeat (6) cycle();

        // Redirect with nothing in flight
        waitIdle();
        flush = 1'b1; brTarget = 16'h0040;
        cycle();
        flush = 1'b0;
        repeat (8) cycle();

        // Redirect while the request to 0005 is still in flight
        reset = 1'b1;
        cycle();
        reset = 1'b0; memLat = 3;
        g = 0;
        while (!(justIssued && lastIssued == 16'h0005) && g < 100) begin
            cycle();
            g++;
        end
        check("reach_0005", {15'd0, justIssued}, 16'd1);
        flush = 1'b1; brTarget = 16'h0040;
        cycle();
        flush = 1'b0;
        repeat (10) cycle();

        // PC wrap from FFFF
        memLat = 1;
        waitIdle();
        flush = 1'b1; brTarget = 16'hFFFF;
        cycle();
        flush = 1'b0;
        repeat (6) cycle();

        // Reset while a request is outstanding; its response lands after release
        memLat = 2;
        g = 0;
        do begin
            cycle();
            g++;
        end while (!justIssued && g < 20);
        check("issue_before_reset", {15'd0, justIssued}, 16'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (8) cycle();

        // Randomized traffic
        randGnt = 1'b1; randLat = 1'b1; spurious = 1'b1;
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            flush    = !reset && ($urandom_range(0, 19) == 0);
            brTarget = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            stall    = ($urandom_range(0, 9) < 3);
            cycle();
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage of SimpleCore. Sits directly upstream of the control/decode path and supplies the 16-bit instruction word (fInst) consumed by decode.
- Generates the instruction address (PC) and runs a request/response handshake to instruction memory.
- Buffers returned words in a small prefetch FIFO.
- Handles branch redirects (flush + target) and reports pipeline refill while the queue is re-priming.

Parameters:
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
RESET_PC, 16'h0000, PC value after reset
NOP_INST, 16'h0000, word driven on fInst when no valid instruction is presented

Ports:
clk  input  1  main clock, all state on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  branch taken in execute; redirect fetch
brTarget  input  16  branch target address, valid when flush=1
stall  input  1  decode cannot accept an instruction this cycle
iReq  output  1  instruction memory request
iAddr  output  16  instruction memory address
iGnt  input  1  memory accepts request this cycle (iReq&iGnt = issue)
iRdy  input  1  response word valid on dIn
dIn  input  16  instruction word from memory
fInst  output  16  instruction presented to decode
fValid  output  1  fInst holds a real instruction
refill  output  1  pipeline refilling after flush/reset; consumer treats fInst as bubble

Behaviour:
- Reset (reset=1 at clk edge, overrides all): pc=RESET_PC, FIFO empty (count=0, rd/wr ptr=0), outstanding=0, drop=0, refill=1. Outputs after reset: iReq=0 in the reset cycle, then iReq=1 from the first non-reset cycle with iAddr=RESET_PC, fValid=0, fInst=NOP_INST. Reset asserted mid-transaction discards any in-flight response; a later iRdy for it is ignored because drop=0 and outstanding=0 (iRdy with outstanding=0 is ignored).
- Outstanding limit: at most one request in flight. iReq=1 when ~reset & outstanding=0 & (count + 0) < DEPTH; also when flush=1 (see below). iAddr=pc, or brTarget when flush=1 (combinational bypass).
- Issue: iReq&iGnt sets outstanding=1, pc<=iAddr+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
- Response: iRdy&outstanding clears outstanding. If drop=0, dIn is written at wr ptr and count increments. If drop=1, the word is discarded and drop clears.
- Dequeue: head entry is presented combinationally: fInst=fifo[rd], fValid=(count>0). When count=0: fInst=NOP_INST, fValid=0. Pop when fValid & ~stall & ~flush.
- Same-cycle push and pop: count unchanged. Push into full FIFO cannot occur because issue requires count<DEPTH, counting the in-flight word via outstanding.
- Flush (priority over pop/push): FIFO cleared (count=0, pointers=0). If outstanding=1 and the response does not arrive this cycle, drop<=1. Redirect request to brTarget is issued the same cycle only if outstanding=0 or iRdy=1 that cycle; otherwise pc<=brTarget and the request goes out after the dropped word returns. refill<=1.
- refill: set by reset or flush, cleared on the first cycle a valid instruction is popped (fValid & ~stall). refill is a registered output.
- stall with count=0: no effect. stall holds head; fetch continues until FIFO full.

Test Plan:
- Reset then iGnt=1, iRdy 1 cycle after each grant, dIn=16'hA000+addr, stall=0 -> iAddr sequence 0,1,2,3; fInst A000,A001,A002 in order; fValid=1 from the cycle after first iRdy; refill drops after the first pop.
- stall=1 for 6 cycles with continuous memory -> after 2 words captured iReq=0; fInst holds A000; on release 2 words drain in order with no loss or duplicate.
- flush with brTarget=16'h0040 while outstanding=0 -> same-cycle iAddr=0040, FIFO emptied, fValid=0, refill=1; next instructions come from 0040, 0041.
- flush while a request to 0005 is outstanding and iRdy arrives 2 cycles later -> word for 0005 discarded; next request iAddr=0040; fInst never shows the 0005 word.
- pc=16'hFFFF granted -> next iAddr=16'h0000.
- reset asserted with outstanding=1, late iRdy the cycle after reset is released -> word ignored; first captured word is from RESET_PC.
